// File: rtl/ecall_sequencer_pkg.sv
// Shared constants for the ECALL path: service codes, argument register
// indices and the sequencer state encoding.
package ecall_sequencer_pkg;

    localparam int SYS_PRINT_INT = 1;
    localparam int SYS_READ_INT  = 5;
    localparam int SYS_EXIT      = 10;

    localparam int REG_A0 = 10;
    localparam int REG_A7 = 17;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_DONE         = 3'd3,
        ST_HALT         = 3'd4
    } state_t;

    typedef enum logic {
        OP_PRINT = 1'b0,
        OP_READ  = 1'b1
    } op_t;

endpackage

// File: rtl/ecall_sequencer_debounce.sv
// Confirm-button conditioner: two-flop synchroniser followed by a stability
// counter; emits the debounced level and a one-cycle pulse on its rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             cnt_full;

    assign cnt_full = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any disagreement with the current level must persist for the whole
    // window; a single matching sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt_full) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecall_sequencer.sv
// ECALL service sequencer: stalls the core while printing to the segment
// latch, reading the switches into a0, or halting on exit.
module ecall_sequencer
    import ecall_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_WIDTH        = 16,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ecall,
    input  logic [DATA_WIDTH-1:0] a7,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [SW_WIDTH-1:0]   sw,
    input  logic                  btn_confirm,
    output logic                  stall,
    output logic                  wb_en,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] seg_data,
    output logic                  halted
);

    localparam int EXT_W = DATA_WIDTH - SW_WIDTH;

    state_t                state;
    state_t                next_state;
    op_t                   op;
    logic [DATA_WIDTH-1:0] rd_reg;
    logic                  btn_level;
    logic                  btn_rise;
    logic                  is_print;
    logic                  is_read;
    logic                  is_exit;

    assign is_print = (a7 == DATA_WIDTH'(SYS_PRINT_INT));
    assign is_read  = (a7 == DATA_WIDTH'(SYS_READ_INT));
    assign is_exit  = (a7 == DATA_WIDTH'(SYS_EXIT));

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_confirm),
        .level(btn_level),
        .rise (btn_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture: the print value is latched on entry, the switch value
    // only on the accepted press so the user can adjust switches while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_data <= '0;
            op       <= OP_PRINT;
            rd_reg   <= '0;
        end else begin
            if (state == ST_IDLE && ecall) begin
                if (is_print) begin
                    seg_data <= a0;
                    op       <= OP_PRINT;
                end else if (is_read) begin
                    op <= OP_READ;
                end
            end
            if (state == ST_WAIT_PRESS && btn_rise && op == OP_READ) begin
                rd_reg <= {{EXT_W{sw[SW_WIDTH-1]}}, sw};
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (ecall) begin
                    if (is_print || is_read) begin
                        next_state = ST_WAIT_PRESS;
                    end else if (is_exit) begin
                        next_state = ST_HALT;
                    end
                end
            end
            ST_WAIT_PRESS: begin
                if (btn_rise) begin
                    next_state = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!btn_level) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Stall is combinational in IDLE so the PC never moves past the ecall.
    always_comb begin
        stall  = 1'b0;
        wb_en  = 1'b0;
        halted = 1'b0;
        unique case (state)
            ST_IDLE: begin
                stall = ecall && (is_print || is_read || is_exit);
            end
            ST_WAIT_PRESS, ST_WAIT_RELEASE: begin
                stall = 1'b1;
            end
            ST_DONE: begin
                wb_en = (op == OP_READ);
            end
            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign wb_data = wb_en ? rd_reg : '0;

endmodule

// File: tb/tb_ecall_sequencer.sv
// Directed self-checking bench for ecall_sequencer with a short debounce
// window so every press/release timing can be worked out by hand.
module tb_ecall_sequencer;

    localparam int DW  = 32;
    localparam int SWW = 16;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ecall;
    logic [DW-1:0] a7;
    logic [DW-1:0] a0;
    logic [SWW-1:0] sw;
    logic          btn_confirm;
    logic          stall;
    logic          wb_en;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] seg_data;
    logic          halted;

    int checks    = 0;
    int failures  = 0;
    int wb_pulses = 0;
    int wb_leak   = 0;

    ecall_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SW_WIDTH       (SWW),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ecall      (ecall),
        .a7         (a7),
        .a0         (a0),
        .sw         (sw),
        .btn_confirm(btn_confirm),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_data    (wb_data),
        .seg_data   (seg_data),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_en) wb_pulses++;
        if (!wb_en && wb_data != '0) wb_leak++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Press for 'hi' cycles then release, stopping at the first cycle with stall low.
    task automatic press_until_done(input int hi, input int budget, output int ticks,
                                    output logic wbe, output logic [DW-1:0] wbd);
        ticks = -1;
        wbe   = 1'b0;
        wbd   = '0;
        for (int i = 0; i < budget; i++) begin
            btn_confirm = (i < hi);
            tick();
            if (!stall) begin
                ticks = i + 1;
                wbe   = wb_en;
                wbd   = wb_data;
                btn_confirm = 1'b0;
                return;
            end
        end
        btn_confirm = 1'b0;
        checks++;
        failures++;
        $display("[TB] FAIL done_timeout: stall=%0b after %0d cycles, required 0", stall, budget);
    endtask

    task automatic test_reset;
        rst = 1'b1; ecall = 1'b0; a7 = '0; a0 = '0; sw = '0; btn_confirm = 1'b0;
        #2;
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b, expected 0", stall); end
        checks++; if (wb_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_en: got %b, expected 0", wb_en); end
        checks++; if (wb_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_wb_data: got %h, expected 0", wb_data); end
        checks++; if (seg_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_seg: got %h, expected 0", seg_data); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %b, expected 0", halted); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_print_back_to_back;
        int t; logic wbe; logic [DW-1:0] wbd;
        wb_pulses = 0;
        ecall = 1'b1; a7 = 32'd1; a0 = 32'h2A;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL print_stall_first: got %b, expected 1", stall); end
        tick();
        checks++; if (seg_data !== 32'h2A) begin failures++; $display("[TB] FAIL print_seg: got %h, expected 0000002a", seg_data); end
        press_until_done(6, 60, t, wbe, wbd);
        checks++; if (t !== 13) begin failures++; $display("[TB] FAIL print_latency: got %0d, expected 13", t); end
        checks++; if (wbe !== 1'b0) begin failures++; $display("[TB] FAIL print_done_wb_en: got %b, expected 0", wbe); end
        a0 = 32'h55;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL done_ignores_ecall: got %b, expected 0", stall); end
        tick();
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL single_done_cycle: got %b, expected 1", stall); end
        checks++; if (seg_data !== 32'h2A) begin failures++; $display("[TB] FAIL seg_hold: got %h, expected 0000002a", seg_data); end
        tick();
        checks++; if (seg_data !== 32'h55) begin failures++; $display("[TB] FAIL print2_seg: got %h, expected 00000055", seg_data); end
        press_until_done(6, 60, t, wbe, wbd);
        checks++; if (t !== 13) begin failures++; $display("[TB] FAIL print2_latency: got %0d, expected 13", t); end
        ecall = 1'b0;
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL print_idle_stall: got %b, expected 0", stall); end
        checks++; if (wb_pulses !== 0) begin failures++; $display("[TB] FAIL print_wb_pulses: got %0d, expected 0", wb_pulses); end
    endtask

    task automatic test_read;
        int t; logic wbe; logic [DW-1:0] wbd;
        wb_pulses = 0; wb_leak = 0;
        ecall = 1'b1; a7 = 32'd5; sw = 16'h8001;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL read_stall_first: got %b, expected 1", stall); end
        tick();
        press_until_done(6, 60, t, wbe, wbd);
        checks++; if (t !== 13) begin failures++; $display("[TB] FAIL read_latency: got %0d, expected 13", t); end
        checks++; if (wbe !== 1'b1) begin failures++; $display("[TB] FAIL read_wb_en: got %b, expected 1", wbe); end
        checks++; if (wbd !== 32'hFFFF_8001) begin failures++; $display("[TB] FAIL read_wb_data: got %h, expected ffff8001", wbd); end
        ecall = 1'b0;
        tick();
        checks++; if (wb_en !== 1'b0 || wb_data !== 32'h0) begin failures++; $display("[TB] FAIL read_after_done: got wb_en=%b wb_data=%h, expected 0/0", wb_en, wb_data); end
        tick();
        checks++; if (wb_pulses !== 1) begin failures++; $display("[TB] FAIL read_wb_pulses: got %0d, expected 1", wb_pulses); end
        checks++; if (wb_leak !== 0) begin failures++; $display("[TB] FAIL read_wb_data_leak: got %0d, expected 0", wb_leak); end
        checks++; if (seg_data !== 32'h55) begin failures++; $display("[TB] FAIL read_seg_hold: got %h, expected 00000055", seg_data); end
    endtask

    task automatic test_bounce;
        int t; int stall_low; logic wbe; logic [DW-1:0] wbd;
        wb_pulses = 0; stall_low = 0;
        ecall = 1'b1; a7 = 32'd5; sw = 16'h1234;
        tick();
        for (int i = 0; i < 11; i++) begin
            btn_confirm = (i == 0 || i == 2);
            tick();
            if (!stall) stall_low++;
        end
        checks++; if (stall_low !== 0) begin failures++; $display("[TB] FAIL bounce_no_transition: got %0d stall-low cycles, expected 0", stall_low); end
        press_until_done(5, 60, t, wbe, wbd);
        checks++; if (t !== 12) begin failures++; $display("[TB] FAIL bounce_latency: got %0d, expected 12", t); end
        checks++; if (wbd !== 32'h0000_1234) begin failures++; $display("[TB] FAIL bounce_wb_data: got %h, expected 00001234", wbd); end
        ecall = 1'b0;
        tick(); tick();
        checks++; if (wb_pulses !== 1) begin failures++; $display("[TB] FAIL bounce_wb_pulses: got %0d, expected 1", wb_pulses); end
    endtask

    task automatic test_held_button;
        int t; int stall_low; logic wbe; logic [DW-1:0] wbd;
        stall_low = 0;
        btn_confirm = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        ecall = 1'b1; a7 = 32'd5; sw = 16'hAAAA;
        tick();
        for (int i = 0; i < 14; i++) begin
            btn_confirm = (i < 6);
            tick();
            if (!stall) stall_low++;
        end
        checks++; if (stall_low !== 0) begin failures++; $display("[TB] FAIL held_no_accept: got %0d stall-low cycles, expected 0", stall_low); end
        sw = 16'h0042;
        press_until_done(6, 60, t, wbe, wbd);
        checks++; if (t !== 13) begin failures++; $display("[TB] FAIL held_latency: got %0d, expected 13", t); end
        checks++; if (wbd !== 32'h0000_0042) begin failures++; $display("[TB] FAIL held_wb_data: got %h, expected 00000042", wbd); end
        ecall = 1'b0;
        tick();
    endtask

    task automatic test_noop;
        ecall = 1'b1; a7 = 32'd3; a0 = 32'h99;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL noop_stall: got %b, expected 0", stall); end
        checks++; if (wb_en !== 1'b0) begin failures++; $display("[TB] FAIL noop_wb_en: got %b, expected 0", wb_en); end
        tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL noop_stays_idle: got %b, expected 0", stall); end
        checks++; if (seg_data !== 32'h55) begin failures++; $display("[TB] FAIL noop_seg_hold: got %h, expected 00000055", seg_data); end
        ecall = 1'b0;
        tick();
    endtask

    task automatic test_exit;
        int bad;
        bad = 0;
        ecall = 1'b1; a7 = 32'd10;
        #1;
        checks++; if (stall !== 1'b1 || halted !== 1'b0) begin failures++; $display("[TB] FAIL exit_first: got stall=%b halted=%b, expected 1/0", stall, halted); end
        tick();
        ecall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            btn_confirm = ((i % 12) < 6);
            tick();
            if (!(halted && stall) || wb_en) bad++;
        end
        btn_confirm = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL exit_halt_held: got %0d bad cycles, expected 0", bad); end
    endtask

    task automatic test_reset_mid;
        int t; logic wbe; logic [DW-1:0] wbd;
        #2 rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0 || stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_from_halt: got halted=%b stall=%b, expected 0/0", halted, stall); end
        #1 rst = 1'b0;
        tick();
        ecall = 1'b1; a7 = 32'd1; a0 = 32'h7;
        tick();
        checks++; if (seg_data !== 32'h7) begin failures++; $display("[TB] FAIL mid_seg: got %h, expected 00000007", seg_data); end
        btn_confirm = 1'b1;
        tick(); tick();
        #2;
        rst = 1'b1; ecall = 1'b0; btn_confirm = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_stall: got %b, expected 0", stall); end
        checks++; if (seg_data !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_seg: got %h, expected 0", seg_data); end
        checks++; if (wb_en !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_flags: got wb_en=%b halted=%b, expected 0/0", wb_en, halted); end
        #1 rst = 1'b0;
        tick();
        ecall = 1'b1; a7 = 32'd1; a0 = 32'h0BAD;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_accept: got %b, expected 1", stall); end
        tick();
        checks++; if (seg_data !== 32'h0BAD) begin failures++; $display("[TB] FAIL post_reset_seg: got %h, expected 00000bad", seg_data); end
        press_until_done(6, 60, t, wbe, wbd);
        checks++; if (t !== 13) begin failures++; $display("[TB] FAIL post_reset_latency: got %0d, expected 13", t); end
        ecall = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_print_back_to_back();
        test_read();
        test_bounce();
        test_held_button();
        test_noop();
        test_exit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecall_sequencer.md
Name: ecall_sequencer

Overview:
- Multi-cycle sequencer that services the ECALL instruction for the single-cycle core.
- When the decoder flags an ecall, the block stalls the PC and register file, then performs one I/O service selected by register a7:
  - print integer to the 7-segment latch,
  - read integer from the switches,
  - exit/halt.
- On completion it releases the stall, and for reads writes the result back to a0.
- Sits between the decoder's ecall output, the register file's a0/a7 read ports and the board I/O (switches, confirm button, segment driver).

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the raw button must be stable before the debounced level changes (10 ms at 100 MHz).
- SW_WIDTH, 16, number of input switches.
- DATA_WIDTH, 32, register width; equals the core's REGWIDTH.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ecall  in  1  decoder flag; held high for the whole time the ecall instruction is at the PC.
- a7  in  DATA_WIDTH  service code read from x17.
- a0  in  DATA_WIDTH  argument read from x10.
- sw  in  SW_WIDTH  raw switches, already synchronised at board level.
- btn_confirm  in  1  raw, asynchronous confirm button.
- stall  out  1  when 1, the PC holds and RegWrite is suppressed for the ecall instruction.
- wb_en  out  1  one-cycle write strobe to x10.
- wb_data  out  DATA_WIDTH  write data for x10.
- seg_data  out  DATA_WIDTH  value shown on the 7-segment display.
- halted  out  1  core halted by exit.

Behaviour:
- Service codes: 1 = PRINT_INT, 5 = READ_INT, 10 = EXIT. Any other a7 is a no-op: stall stays 0, the instruction retires in one cycle and no state change occurs.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE, HALT.
- IDLE:
  - stall = ecall && (a7 is 1, 5 or 10); combinational, so the PC never advances on the first ecall cycle.
  - On ecall with a7 = 1: seg_data <= a0; latch op; go to WAIT_PRESS.
  - On ecall with a7 = 5: latch op; go to WAIT_PRESS.
  - On ecall with a7 = 10: go to HALT.
- WAIT_PRESS:
  - stall = 1.
  - On the debounced rising edge of the button: if op = READ, capture rd_reg <= sign-extend(sw) to DATA_WIDTH. Then go to WAIT_RELEASE.
- WAIT_RELEASE:
  - stall = 1.
  - On debounced level 0, go to DONE. This guarantees one press satisfies exactly one ecall.
- DONE:
  - stall = 0, so the PC advances at the end of this cycle.
  - wb_en = 1 only if op = READ, with wb_data = rd_reg.
  - ecall is ignored in this state.
  - Next state is IDLE unconditionally.
- HALT:
  - stall = 1, halted = 1.
  - Only rst exits this state.
- Latency:
  - No-op: 0 extra cycles.
  - PRINT/READ: 1 (IDLE) + press wait + release wait + 1 (DONE); minimum DEBOUNCE_CYCLES + 1 cycles each way after the button edges.
- Button pressed before entering WAIT_PRESS (held across the ecall): no edge is seen, so the user must release and press again.
- ecall dropping mid-service cannot happen architecturally, since the PC is stalled. The FSM does not monitor ecall outside IDLE.
- Reset (asynchronous, any state including mid-service):
  - state = IDLE; stall = 0, wb_en = 0, wb_data = 0, seg_data = 0, halted = 0.
  - Debouncer counter = 0 and debounced level = 0.
- wb_data is 0 whenever wb_en = 0.
- seg_data holds its last printed value across later ecalls and no-ops.

Decomposition:
- Shared variables header (same include as the decoder constants):
  - service codes SYS_PRINT_INT = 1, SYS_READ_INT = 5, SYS_EXIT = 10;
  - state encodings (3-bit);
  - register indices A0 = 10, A7 = 17.
- One sub-module, btn_debounce:
  - 2-flop synchroniser plus a stability counter of width clog2(DEBOUNCE_CYCLES+1);
  - outputs the debounced level and a one-cycle rise pulse;
  - same clk/rst.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset during WAIT_PRESS with seg_data = 7: assert rst → stall = 0, seg_data = 0, state = IDLE immediately, without waiting for a clock edge.
- ecall with a7 = 1, a0 = 0x0000_002A → stall = 1 in the same cycle, seg_data = 0x2A next cycle. Press 6 cycles, release 6 cycles → exactly one DONE cycle with stall = 0 and wb_en = 0.
- ecall with a7 = 5, sw = 0x8001, press/release → DONE cycle shows wb_en = 1, wb_data = 0xFFFF_8001; wb_en is 0 in every other cycle.
- Button bouncing (toggle each cycle for 3 cycles) during WAIT_PRESS → no transition. Stable high for 5 cycles → exactly one rise pulse accepted.
- Button held high when the READ ecall arrives → stays in WAIT_PRESS until release then re-press; wb_data reflects sw at the second press.
- ecall with a7 = 3 → stall = 0 in that cycle, no wb_en, state remains IDLE. ecall with a7 = 10 → halted = 1 and stall = 1 persist for 100 cycles despite button presses.
